operand_sequencer: RTL and testbench

OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

---
 rtl/operand_sequencer.sv | 101 ++++++++++
 tb/tb_operand_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - sequences two operand beats into an external 4-bit adder and registers its result
//
// Purpose: accepts operand A then operand B from a shared valid/ready bus,
// presents them to an external combinational adder, captures {Carry,Sum}
// one cycle later, and holds the result until the consumer takes it.
// A saturating counter records how many captured results carried out.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   din, din_valid      operand beat from the producer (A first, then B)
//   din_ready           beat is accepted this cycle
//   A, B                registered operands driven to the adder
//   Sum, Carry          adder outputs, sampled in the capture cycle
//   result, res_valid   registered {Carry,Sum} and its valid flag
//   res_ready           consumer takes result this cycle
//   carry_cnt           saturating count of results captured with Carry=1
module operand_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [3:0]       A,
  output logic [3:0]       B,
  input  logic [3:0]       Sum,
  input  logic             Carry,
  output logic [4:0]       result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] carry_cnt
);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    CAPTURE = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   load_a, load_b, capture, release_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD_A;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    // Gated by rst so the producer never sees a ready while reset is held.
    din_ready   = ~rst & ((state == LOAD_A) | (state == LOAD_B));
    load_a      = 1'b0;
    load_b      = 1'b0;
    capture     = 1'b0;
    release_res = 1'b0;
    case (state)
      LOAD_A: begin
        load_a = din_valid & din_ready;
        if (load_a) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        load_b = din_valid & din_ready;
        if (load_b) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        // A and B are stable from the previous edge, so the adder has settled.
        capture   = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        release_res = res_ready;
        if (res_ready) state_nxt = LOAD_A;
      end
      default: state_nxt = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      A         <= 4'h0;
      B         <= 4'h0;
      result    <= 5'h00;
      res_valid <= 1'b0;
      carry_cnt <= '0;
    end else begin
      if (load_a) A <= din;
      if (load_b) B <= din;
      if (capture) begin
        result    <= {Carry, Sum};
        res_valid <= 1'b1;
        // Saturate at all-ones instead of wrapping.
        if (Carry && (carry_cnt != {CNT_W{1'b1}}))
          carry_cnt <= carry_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (release_res) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - self-checking bench for operand_sequencer
module tb_operand_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       res_ready;

  logic       din_ready, din_ready2;
  logic [3:0] a_o, b_o, a2_o, b2_o;
  logic [3:0] sum, sum2;
  logic       carry, carry2;
  logic [4:0] result, result2;
  logic       res_valid, res_valid2;
  logic [7:0] carry_cnt;
  logic [1:0] carry_cnt2;

  int checks   = 0;
  int failures = 0;
  int cnt_model = 0;

  always #5 clk = ~clk;

  // External adders, one per instance.
  assign {carry, sum}   = {1'b0, a_o}  + {1'b0, b_o};
  assign {carry2, sum2} = {1'b0, a2_o} + {1'b0, b2_o};

  operand_sequencer #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .A(a_o), .B(b_o), .Sum(sum), .Carry(carry), .result(result),
    .res_valid(res_valid), .res_ready(res_ready), .carry_cnt(carry_cnt)
  );

  operand_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready2),
    .A(a2_o), .B(b2_o), .Sum(sum2), .Carry(carry2), .result(result2),
    .res_valid(res_valid2), .res_ready(res_ready), .carry_cnt(carry_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic send_beat(input logic [3:0] v, input int gaps);
    logic rdy;
    for (int g = 0; g < gaps; g++) begin
      din       = 4'($urandom);
      din_valid = 1'b0;
      @(posedge clk); #1;
    end
    din       = v;
    din_valid = 1'b1;
    rdy       = 1'b0;
    for (int t = 0; t < 20 && !rdy; t++) begin
      @(negedge clk);
      rdy = din_ready;
      @(posedge clk); #1;
    end
    check("beat_accept", {31'b0, rdy}, 32'd1);
    din_valid = 1'b0;
    din       = 4'($urandom);
  endtask

  task automatic run_pair(input logic [3:0] a, input logic [3:0] b, input int hold, input int gaps);
    int sumv;
    sumv      = int'(a) + int'(b);
    res_ready = 1'($urandom);
    send_beat(a, gaps);
    check("a_loaded", {28'b0, a_o}, {28'b0, a});
    send_beat(b, gaps);
    check("b_loaded", {28'b0, b_o}, {28'b0, b});
    check("a_held_cap", {28'b0, a_o}, {28'b0, a});
    check("valid_in_capture", {31'b0, res_valid}, 32'd0);
    check("ready_in_capture", {31'b0, din_ready}, 32'd0);
    // Stray valid beats while busy must be ignored.
    res_ready = (hold == 0);
    din_valid = 1'($urandom);
    din       = 4'($urandom);
    if (sumv > 15) cnt_model++;
    @(posedge clk); #1;
    check("res_valid_latency", {31'b0, res_valid}, 32'd1);
    check("result", {27'b0, result}, sumv);
    check("carry_cnt", {24'b0, carry_cnt}, sat(cnt_model, 255));
    check("carry_cnt_sat2", {30'b0, carry_cnt2}, sat(cnt_model, 3));
    check("result_w2", {27'b0, result2}, sumv);
    for (int h = 0; h < hold; h++) begin
      din_valid = 1'b1;
      din       = 4'($urandom);
      @(posedge clk); #1;
      check("hold_valid", {31'b0, res_valid}, 32'd1);
      check("hold_result", {27'b0, result}, sumv);
      check("hold_ready", {31'b0, din_ready}, 32'd0);
      check("hold_a", {28'b0, a_o}, {28'b0, a});
    end
    res_ready = 1'b1;
    din_valid = 1'b0;
    @(posedge clk); #1;
    check("res_released", {31'b0, res_valid}, 32'd0);
    check("ready_after_out", {31'b0, din_ready}, 32'd1);
    check("a_not_overwritten", {28'b0, a_o}, {28'b0, a});
    check("b_not_overwritten", {28'b0, b_o}, {28'b0, b});
    res_ready = 1'($urandom);
  endtask

  initial begin
    rst       = 1'b1;
    din       = 4'h0;
    din_valid = 1'b0;
    res_ready = 1'b0;
    #3;
    check("rst_ready", {31'b0, din_ready}, 32'd0);
    check("rst_result", {27'b0, result}, 32'd0);
    check("rst_valid", {31'b0, res_valid}, 32'd0);
    check("rst_cnt", {24'b0, carry_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {31'b0, din_ready}, 32'd1);

    run_pair(4'h3, 4'h4, 0, 0);
    run_pair(4'hF, 4'h1, 0, 0);
    run_pair(4'hF, 4'hF, 0, 0);
    run_pair(4'($urandom), 4'($urandom), 5, 0);
    run_pair(4'($urandom), 4'($urandom), 0, 2);
    for (int i = 0; i < 16; i++)
      run_pair(4'($urandom), 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 2));
    for (int i = 0; i < 3; i++)
      run_pair(4'($urandom_range(8, 15)), 4'($urandom_range(8, 15)), 0, 0);

    // Reset in the middle of loading B.
    send_beat(4'h9, 0);
    check("a_before_rst", {28'b0, a_o}, 32'h9);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_a", {28'b0, a_o}, 32'd0);
    check("midrst_b", {28'b0, b_o}, 32'd0);
    check("midrst_result", {27'b0, result}, 32'd0);
    check("midrst_valid", {31'b0, res_valid}, 32'd0);
    check("midrst_cnt", {24'b0, carry_cnt}, 32'd0);
    check("midrst_cnt2", {30'b0, carry_cnt2}, 32'd0);
    check("midrst_ready", {31'b0, din_ready}, 32'd0);
    cnt_model = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_pair(4'h2, 4'h2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
